// File: rtl/issue_scheduler.sv
// Issue-stage interlock: holds a decoded control word until its sources are clear of
// in-flight destinations and the multiplier is free. Optional macro: FORWARD_EN.
module issue_scheduler #(
  parameter int PIPE_DEPTH = 3,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ctrl_in,
  input  logic             ctrl_valid,
  output logic             ctrl_ready,
  output logic [31:0]      issue_ctrl,
  output logic             issue_valid,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MUL_BUSY = 1'b1;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_t;

  logic                  wr_regfile, alu_imm, d_sel, cs, wr;
  logic [4:0]            rs, rt, rd;
  logic                  rt_used, dst_vld;
  logic                  hazard, accept;

  logic [0:0]            state_q, state_d;
  logic [MC_W-1:0]       mul_cnt_q, mul_cnt_d;
  sb_t [PIPE_DEPTH-1:0]  sb_q, sb_d;
  logic [PIPE_DEPTH-1:0] hit, chk, ld_vec;
  logic [31:0]           issue_ctrl_q;
  logic                  issue_valid_q;
  logic [CNT_W-1:0]      stall_q;
  logic                  unused_ld;

  assign wr_regfile = ctrl_in[22];
  assign rs         = ctrl_in[21:17];
  assign rt         = ctrl_in[16:12];
  assign rd         = ctrl_in[11:7];
  assign alu_imm    = ctrl_in[6];
  assign d_sel      = ctrl_in[5];
  assign cs         = ctrl_in[2];
  assign wr         = ctrl_in[1];

  // rt is read by R-type ops and as store data; for loads it is only a destination.
  assign rt_used = ~alu_imm | (cs & wr);
  assign dst_vld = wr_regfile & (rd != 5'd0);

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_hit
    assign hit[g]    = sb_q[g].v & ((rs == sb_q[g].rd) | (rt_used & (rt == sb_q[g].rd)));
    assign ld_vec[g] = sb_q[g].ld;
  end

  // The load flag only matters to the compare when forwarding covers everything else.
  assign unused_ld = ^ld_vec;

`ifdef FORWARD_EN
  always_comb begin
    chk    = '0;
    chk[0] = sb_q[0].ld;
  end
`else
  assign chk = '1;
`endif

  assign hazard     = ctrl_valid & |(hit & chk);
  assign ctrl_ready = ~rst & (state_q == S_IDLE) & ~hazard;
  assign accept     = ctrl_valid & ctrl_ready;

  always_comb begin
    sb_d = sb_q;
    for (int i = PIPE_DEPTH - 1; i > 0; i--) sb_d[i] = sb_q[i-1];
    sb_d[0].v  = accept & dst_vld;
    sb_d[0].rd = rd;
    sb_d[0].ld = cs & ~wr;
  end

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && d_sel && (MUL_LAT > 1)) begin
          state_d   = S_MUL_BUSY;
          mul_cnt_d = MC_W'(MUL_LAT - 1);
        end
      end
      default: begin
        if (mul_cnt_q <= MC_W'(1)) begin
          state_d   = S_IDLE;
          mul_cnt_d = '0;
        end else begin
          mul_cnt_d = mul_cnt_q - MC_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mul_cnt_q     <= '0;
      sb_q          <= '0;
      issue_ctrl_q  <= '0;
      issue_valid_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      mul_cnt_q     <= mul_cnt_d;
      sb_q          <= sb_d;
      issue_ctrl_q  <= accept ? ctrl_in : 32'h0;
      issue_valid_q <= accept;
      // A cycle blocked by both a hazard and the multiplier still counts once.
      if (ctrl_valid && !ctrl_ready && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign issue_ctrl  = issue_ctrl_q;
  assign issue_valid = issue_valid_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: accepted words are queued and checked on issue.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ctrl_in = 32'h0;
  logic        ctrl_valid = 1'b0;
  logic        ctrl_ready, issue_valid;
  logic [31:0] issue_ctrl;
  logic [15:0] stall_count;
  logic        s_ready, s_ivalid;
  logic [31:0] s_ictrl;
  logic [3:0]  s_stall;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          exp_stall = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_q[$];

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] ADD1 = 32'h00422180;
  localparam logic [31:0] ADD2 = 32'h00461200;
  localparam logic [31:0] LW5  = 32'h004252C5;
  localparam logic [31:0] MUL6 = 32'h00422320;

  issue_scheduler dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready), .issue_ctrl(issue_ctrl), .issue_valid(issue_valid),
    .stall_count(stall_count)
  );

  issue_scheduler #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid),
    .ctrl_ready(s_ready), .issue_ctrl(s_ictrl), .issue_valid(s_ivalid),
    .stall_count(s_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (issue_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL issue_unexpected: got %h, required no issue", issue_ctrl);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (issue_ctrl !== e) begin
            miscompares++;
            $display("FAIL issue_word: got %h, required %h", issue_ctrl, e);
          end
        end
      end else if (issue_valid !== 1'b0 || issue_ctrl !== 32'h0) begin
        miscompares++;
        $display("FAIL bubble: got valid=%b ctrl=%h, required 0/00000000", issue_valid, issue_ctrl);
      end
    end
  end

  function automatic logic [31:0] enc(input logic wrf, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [6:0] lo);
    return {9'b0, wrf, rs, rt, rd, lo};
  endfunction

  task automatic send(input logic [31:0] w, output int acc_cyc, output int stalls);
    stalls = 0;
    ctrl_in = w;
    ctrl_valid = 1'b1;
    @(negedge clk);
    while (ctrl_ready !== 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (ctrl_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: word %h not accepted in %0d cycles", w, stalls);
    end else begin
      exp_q.push_back(w);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    ctrl_valid = 1'b0;
    ctrl_in = 32'h0;
  endtask

  task automatic idle(input int n);
    ctrl_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ctrl_valid = 1'b1;
    ctrl_in = ADD1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors += 4;
    if (ctrl_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, required 0", ctrl_ready); end
    if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ivalid: got %b, required 0", issue_valid); end
    if (issue_ctrl !== 32'h0) begin miscompares++; $display("FAIL reset_ictrl: got %h, required 0", issue_ctrl); end
    if (stall_count !== 16'h0) begin miscompares++; $display("FAIL reset_stall: got %0d, required 0", stall_count); end
    ctrl_valid = 1'b0;
    ctrl_in = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_raw();
    int a1, a2, s1, s2;
    send(ADD1, a1, s1);
    send(ADD2, a2, s2);
    exp_stall += FWD ? 0 : 3;
    vectors += 4;
    if (s1 != 0) begin miscompares++; $display("FAIL raw_first_stall: got %0d, required 0", s1); end
    if (s2 != (FWD ? 0 : 3)) begin miscompares++; $display("FAIL raw_stalls: got %0d, required %0d", s2, FWD ? 0 : 3); end
    if (a2 - a1 != (FWD ? 1 : 4)) begin miscompares++; $display("FAIL raw_gap: got %0d, required %0d", a2 - a1, FWD ? 1 : 4); end
    if (stall_count !== 16'(exp_stall)) begin miscompares++; $display("FAIL raw_count: got %0d, required %0d", stall_count, exp_stall); end
    idle(4);
  endtask

  task automatic test_load_use();
    int a1, a2, s1, s2;
    send(LW5, a1, s1);
    send(enc(1'b1, 5'd5, 5'd1, 5'd7, 7'h00), a2, s2);
    exp_stall += FWD ? 1 : 3;
    vectors += 3;
    if (s2 != (FWD ? 1 : 3)) begin miscompares++; $display("FAIL load_use_stalls: got %0d, required %0d", s2, FWD ? 1 : 3); end
    if (a2 - a1 != (FWD ? 2 : 4)) begin miscompares++; $display("FAIL load_use_gap: got %0d, required %0d", a2 - a1, FWD ? 2 : 4); end
    if (stall_count !== 16'(exp_stall)) begin miscompares++; $display("FAIL load_use_count: got %0d, required %0d", stall_count, exp_stall); end
    idle(4);
  endtask

  task automatic test_mul();
    int a1, a2, a3, s1, s2, s3;
    send(MUL6, a1, s1);
    send(enc(1'b1, 5'd1, 5'd2, 5'd8, 7'h00), a2, s2);
    send(enc(1'b1, 5'd1, 5'd2, 5'd9, 7'h00), a3, s3);
    exp_stall += 3;
    vectors += 5;
    if (s2 != 3) begin miscompares++; $display("FAIL mul_stalls: got %0d, required 3", s2); end
    if (a2 - a1 != 4) begin miscompares++; $display("FAIL mul_gap: got %0d, required 4", a2 - a1); end
    if (s3 != 0) begin miscompares++; $display("FAIL back_to_back_stalls: got %0d, required 0", s3); end
    if (a3 - a2 != 1) begin miscompares++; $display("FAIL back_to_back_gap: got %0d, required 1", a3 - a2); end
    if (stall_count !== 16'(exp_stall)) begin miscompares++; $display("FAIL mul_count: got %0d, required %0d", stall_count, exp_stall); end
    idle(4);
  endtask

  task automatic test_r0_store();
    int a1, a2, a3, a4, s1, s2, s3, s4;
    send(enc(1'b1, 5'd1, 5'd2, 5'd0, 7'h00), a1, s1);
    send(enc(1'b1, 5'd0, 5'd0, 5'd9, 7'h00), a2, s2);
    send(ADD1, a3, s3);
    send(enc(1'b0, 5'd1, 5'd3, 5'd0, 7'h46), a4, s4);
    exp_stall += FWD ? 0 : 3;
    vectors += 4;
    if (s2 != 0) begin miscompares++; $display("FAIL r0_stalls: got %0d, required 0", s2); end
    if (a2 - a1 != 1) begin miscompares++; $display("FAIL r0_gap: got %0d, required 1", a2 - a1); end
    if (s4 != (FWD ? 0 : 3)) begin miscompares++; $display("FAIL store_stalls: got %0d, required %0d", s4, FWD ? 0 : 3); end
    if (stall_count !== 16'(exp_stall)) begin miscompares++; $display("FAIL store_count: got %0d, required %0d", stall_count, exp_stall); end
    idle(4);
  endtask

  task automatic test_reset_mul();
    int a1, a2, s1, s2;
    logic [31:0] dep;
    dep = enc(1'b1, 5'd6, 5'd1, 5'd10, 7'h00);
    send(MUL6, a1, s1);
    @(posedge clk); #1;
    rst = 1'b1;
    ctrl_valid = 1'b1;
    ctrl_in = dep;
    @(negedge clk);
    vectors++;
    if (ctrl_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mul_ready: got %b, required 0", ctrl_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall = 0;
    vectors += 3;
    if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mul_ivalid: got %b, required 0", issue_valid); end
    if (stall_count !== 16'h0) begin miscompares++; $display("FAIL rst_mul_count: got %0d, required 0", stall_count); end
    send(dep, a2, s2);
    if (s2 != 0) begin miscompares++; $display("FAIL rst_mul_dep_stalls: got %0d, required 0", s2); end
    idle(4);
  endtask

  task automatic test_saturation();
    int a1, a2, s1, s2;
    for (int r = 0; r < 6; r++) begin
      send(MUL6, a1, s1);
      send(enc(1'b1, 5'd1, 5'd2, 5'd8, 7'h00), a2, s2);
      exp_stall += 3;
      if (r == 1) begin
        vectors++;
        if (s_stall !== 4'(exp_stall)) begin miscompares++; $display("FAIL sat_partial: got %0d, required %0d", s_stall, exp_stall); end
      end
    end
    idle(6);
    vectors += 3;
    if (s_stall !== 4'hF) begin miscompares++; $display("FAIL sat_hold: got %h, required f", s_stall); end
    if (stall_count !== 16'(exp_stall)) begin miscompares++; $display("FAIL sat_wide_count: got %0d, required %0d", stall_count, exp_stall); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_load_use();
    test_mul();
    test_r0_store();
    test_reset_mul();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
